// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared types and widths for the ALU system sequencer:
//   - state_e : main sequencer states (IDLE, EXEC, FLAG, DONE, STORE)
//   - cmd_t   : one accepted operation request as held in the command register
//   - width constants for selects, function code, data, flags and bytes
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam int SEL_W  = 2;   // MuxASel / MuxBSel / MuxCSel width
  localparam int FUN_W  = 5;   // FunSel width
  localparam int DATA_W = 32;  // ALUOut / res_data width
  localparam int FLAG_W = 4;   // Flags / res_flags width
  localparam int BYTE_W = 8;   // MuxCOut / byte_data width
  localparam int NB_W   = 2;   // bytes-to-stream-minus-one width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_FLAG  = 3'd2,
    ST_DONE  = 3'd3,
    ST_STORE = 3'd4
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0] src_a;
    logic [SEL_W-1:0] src_b;
    logic [FUN_W-1:0] fun;
    logic             wf;
    logic             store;
    logic [NB_W-1:0]  nbytes;
  } cmd_t;

  localparam cmd_t CMD_RESET = '0;

  // True when the byte at position idx is the final one of a (nbytes+1)-byte run.
  function automatic logic is_last_byte(input logic [NB_W-1:0] idx,
                                        input logic [NB_W-1:0] nbytes);
    return idx == nbytes;
  endfunction

endpackage

// File: rtl/alu_system_controller_serializer.sv
// -----------------------------------------------------------------------------
// alu_byte_serializer
// Walks the byte index of a captured result through 0..nbytes, one step per
// accepted byte, and flags the final byte.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start_i         one-cycle pulse from the sequencer that begins a run
//   nbytes_i        bytes-to-stream-minus-one, sampled on start_i
//   byte_ready_i    sink accepts the current byte
//   active_o        a byte is being offered
//   idx_o           current byte index (drives MuxCSel)
//   last_o          current byte is the final one
//   done_o          final byte accepted this cycle
// -----------------------------------------------------------------------------
module alu_byte_serializer
  import alu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [NB_W-1:0] nbytes_i,
  input  logic            byte_ready_i,
  output logic            active_o,
  output logic [NB_W-1:0] idx_o,
  output logic            last_o,
  output logic            done_o
);

  logic            active_q, active_d;
  logic [NB_W-1:0] idx_q, idx_d;
  logic [NB_W-1:0] nbytes_q, nbytes_d;
  logic            accept;

  assign accept   = active_q && byte_ready_i;
  assign active_o = active_q;
  assign idx_o    = idx_q;
  assign last_o   = active_q && is_last_byte(idx_q, nbytes_q);
  assign done_o   = accept && last_o;

  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    nbytes_d = nbytes_q;
    if (start_i) begin
      active_d = 1'b1;
      idx_d    = '0;
      nbytes_d = nbytes_i;
    end else if (accept) begin
      if (last_o) begin
        // Return the index to 0 so MuxCSel rests at its idle value; this is
        // still a change caused by an accepted byte.
        active_d = 1'b0;
        idx_d    = '0;
      end else begin
        idx_d = idx_q + {{(NB_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      nbytes_q <= '0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      nbytes_q <= nbytes_d;
    end
  end

endmodule

// File: rtl/alu_system_controller.sv
// -----------------------------------------------------------------------------
// alu_system_controller
// Sequencer for the ALU system datapath. Accepts one request at a time,
// drives the ALU selects for a single execute cycle, captures result and
// flags, then optionally streams the result LSB-first through MuxC.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   req_valid / req_ready            request handshake (ready only in IDLE)
//   req_src_a, req_src_b, req_fun,
//   req_wf, req_store, req_nbytes    request fields
//   MuxASel, MuxBSel, FunSel, WF,
//   MuxCSel                          controls to the ALU system
//   ALUOut, Flags, MuxCOut           observations from the ALU system
//   res_valid, res_data, res_flags   one-cycle result report
//   byte_valid / byte_ready,
//   byte_data, byte_last             byte stream to an 8-bit sink
// -----------------------------------------------------------------------------
module alu_system_controller
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SEL_W-1:0]  req_src_a,
  input  logic [SEL_W-1:0]  req_src_b,
  input  logic [FUN_W-1:0]  req_fun,
  input  logic              req_wf,
  input  logic              req_store,
  input  logic [NB_W-1:0]   req_nbytes,
  output logic [SEL_W-1:0]  MuxASel,
  output logic [SEL_W-1:0]  MuxBSel,
  output logic [FUN_W-1:0]  FunSel,
  output logic              WF,
  output logic [SEL_W-1:0]  MuxCSel,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [FLAG_W-1:0] Flags,
  input  logic [BYTE_W-1:0] MuxCOut,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [FLAG_W-1:0] res_flags,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_last
);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [FLAG_W-1:0] res_flags_q, res_flags_d;

  logic              ser_start;
  logic              ser_active;
  logic [NB_W-1:0]   ser_idx;
  logic              ser_last;
  logic              ser_done;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    ser_start   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cmd_d.src_a  = req_src_a;
          cmd_d.src_b  = req_src_b;
          cmd_d.fun    = req_fun;
          cmd_d.wf     = req_wf;
          cmd_d.store  = req_store;
          cmd_d.nbytes = req_nbytes;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // The operands are still selected from the command register, so the
        // result is captured here and later operand writes cannot disturb it.
        res_data_d = ALUOut;
        state_d    = ST_FLAG;
      end
      ST_FLAG: begin
        // The ALU flag register was written at the end of EXEC.
        res_flags_d = Flags;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (cmd_q.store) begin
          ser_start = 1'b1;
          state_d   = ST_STORE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STORE: begin
        if (ser_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_RESET;
      res_data_q  <= '0;
      res_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte streaming
  // ---------------------------------------------------------------------------
  alu_byte_serializer u_serializer (
    .clk          (clk),
    .rst          (rst),
    .start_i      (ser_start),
    .nbytes_i     (cmd_q.nbytes),
    .byte_ready_i (byte_ready),
    .active_o     (ser_active),
    .idx_o        (ser_idx),
    .last_o       (ser_last),
    .done_o       (ser_done)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready  = (state_q == ST_IDLE);
  assign MuxASel    = cmd_q.src_a;
  assign MuxBSel    = cmd_q.src_b;
  assign FunSel     = cmd_q.fun;
  assign WF         = (state_q == ST_EXEC) && cmd_q.wf;
  assign res_valid  = (state_q == ST_DONE);
  assign res_data   = res_data_q;
  assign res_flags  = res_flags_q;
  assign MuxCSel    = ser_idx;
  assign byte_valid = ser_active && (state_q == ST_STORE);
  assign byte_last  = ser_last && (state_q == ST_STORE);
  // Combinational pass-through: stable while stalled because MuxCSel is held.
  assign byte_data  = MuxCOut;

endmodule

// File: tb/tb_alu_system_controller.sv
// -----------------------------------------------------------------------------
// Bench for alu_system_controller. The bench also plays the ALU system: four
// A and four B operand registers, a small ALU, a flag register written on WF,
// and the MuxC byte mux.
// -----------------------------------------------------------------------------
module tb_alu_system_controller;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_src_a, req_src_b;
  logic [4:0]  req_fun;
  logic        req_wf, req_store;
  logic [1:0]  req_nbytes;
  logic [1:0]  MuxASel, MuxBSel, MuxCSel;
  logic [4:0]  FunSel;
  logic        WF;
  logic [31:0] ALUOut;
  logic [3:0]  Flags;
  logic [7:0]  MuxCOut;
  logic        res_valid;
  logic [31:0] res_data;
  logic [3:0]  res_flags;
  logic        byte_valid, byte_ready, byte_last;
  logic [7:0]  byte_data;

  alu_system_controller dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src_a  (req_src_a),
    .req_src_b  (req_src_b),
    .req_fun    (req_fun),
    .req_wf     (req_wf),
    .req_store  (req_store),
    .req_nbytes (req_nbytes),
    .MuxASel    (MuxASel),
    .MuxBSel    (MuxBSel),
    .FunSel     (FunSel),
    .WF         (WF),
    .MuxCSel    (MuxCSel),
    .ALUOut     (ALUOut),
    .Flags      (Flags),
    .MuxCOut    (MuxCOut),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_last  (byte_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // ALU system stand-in. Flags = {Z, C, N, V}.
  // ---------------------------------------------------------------------------
  localparam logic [4:0] F_PASSA = 5'd0, F_PASSB = 5'd1, F_ADD = 5'd4,
                         F_SUB = 5'd5, F_AND = 5'd7, F_OR = 5'd8, F_XOR = 5'd9;

  function automatic logic [35:0] alu_eval(input logic [4:0] fun,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (fun)
      F_PASSA: r = a;
      F_PASSB: r = b;
      F_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      F_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      F_AND:   r = a & b;
      F_OR:    r = a | b;
      F_XOR:   r = a ^ b;
      default: r = a;
    endcase
    return {(r == 32'd0), c, r[31], v, r};
  endfunction

  logic [31:0] opa [4];
  logic [31:0] opb [4];
  logic [3:0]  flag_reg = 4'h0;
  logic [35:0] env_eval;

  always_comb env_eval = alu_eval(FunSel, opa[MuxASel], opb[MuxBSel]);
  assign ALUOut  = env_eval[31:0];
  assign Flags   = flag_reg;
  assign MuxCOut = ALUOut[{MuxCSel, 3'b000} +: 8];

  always @(posedge clk) if (WF) flag_reg <= env_eval[35:32];

  int n_accept = 0;
  int n_wf = 0;
  always @(posedge clk) begin
    if (rst && req_valid && req_ready) n_accept <= n_accept + 1;
    if (WF) n_wf <= n_wf + 1;
  end

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [4:0] fun;
    logic       wf;
    logic       store;
    logic [1:0] nb;
  } op_t;

  typedef struct {
    op_t         op;
    logic [31:0] exp_data;
    logic [3:0]  exp_flags;
    int          stall;     // stall cycles before byte 0; -1 = random per byte
  } vec_t;

  int   n_vec = 0;
  int   n_fail = 0;
  int   op_id = 0;
  logic [3:0] model_flags = 4'h0;

  function automatic op_t mk_op(input logic [1:0] a, input logic [1:0] b,
                                input logic [4:0] fun, input logic wf,
                                input logic store, input logic [1:0] nb);
    op_t o;
    o.a = a; o.b = b; o.fun = fun; o.wf = wf; o.store = store; o.nb = nb;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (op %0d): got %h, expected %h", name, op_id, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input op_t op);
    req_src_a  = op.a;
    req_src_b  = op.b;
    req_fun    = op.fun;
    req_wf     = op.wf;
    req_store  = op.store;
    req_nbytes = op.nb;
  endtask

  task automatic check_reset_outs();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_muxa", MuxASel, 0);
    chk("rst_muxb", MuxBSel, 0);
    chk("rst_fun", FunSel, 0);
    chk("rst_wf", WF, 0);
    chk("rst_muxc", MuxCSel, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_flags", res_flags, 0);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_last", byte_last, 0);
  endtask

  // One full transaction, cycle by cycle from acceptance to the return of
  // req_ready. With hold set, req_valid stays high carrying nxt while busy.
  task automatic run_op(input op_t op, input logic [31:0] exp_data,
                        input logic [3:0] exp_flags, input int stall,
                        input bit hold, input op_t nxt);
    int wait_n;
    int wf0;
    int st;
    logic [7:0] eb;
    op_id++;
    drive_req(op);
    req_valid = 1'b1;
    wait_n = 0;
    while (!req_ready && wait_n < 50) begin
      tick();
      wait_n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    wf0 = n_wf;
    tick();                                   // accepted at this edge
    if (hold) drive_req(nxt); else req_valid = 1'b0;
    // EXEC
    chk("exec_req_ready", req_ready, 0);
    chk("exec_wf", WF, op.wf);
    chk("exec_muxa", MuxASel, op.a);
    chk("exec_muxb", MuxBSel, op.b);
    chk("exec_fun", FunSel, op.fun);
    chk("exec_res_valid", res_valid, 0);
    tick();
    // FLAG
    chk("flag_wf", WF, 0);
    chk("flag_res_valid", res_valid, 0);
    tick();
    // DONE
    chk("done_res_valid", res_valid, 1);
    chk("done_res_data", res_data, exp_data);
    chk("done_res_flags", res_flags, exp_flags);
    chk("done_byte_valid", byte_valid, 0);
    tick();
    if (op.store) begin
      for (int i = 0; i <= int'(op.nb); i++) begin
        if (stall < 0) st = $urandom_range(0, 3);
        else           st = (i == 0) ? stall : 0;
        eb = exp_data[i*8 +: 8];
        for (int s = 0; s <= st; s++) begin
          byte_ready = (s == st);
          chk("store_byte_valid", byte_valid, 1);
          chk("store_byte_data", byte_data, eb);
          chk("store_muxc", MuxCSel, i);
          chk("store_byte_last", byte_last, (i == int'(op.nb)));
          chk("store_req_ready", req_ready, 0);
          tick();
        end
      end
      byte_ready = 1'b0;
    end
    chk("end_req_ready", req_ready, 1);
    chk("end_byte_valid", byte_valid, 0);
    chk("wf_pulses", n_wf - wf0, op.wf);
    model_flags = exp_flags;
  endtask

  function automatic logic [35:0] model(input op_t op);
    logic [35:0] e;
    e = alu_eval(op.fun, opa[op.a], opb[op.b]);
    if (!op.wf) e[35:32] = model_flags;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    vec_t        tab [9];
    op_t         idle_op;
    op_t         c1, c2, rnd;
    logic [35:0] e1, e2, er;
    int          acc0;

    opa[0] = 32'h0000_0000; opa[1] = 32'hFFFF_FFFF; opa[2] = 32'd5;  opa[3] = 32'hA1B2_C3D4;
    opb[0] = 32'h0000_0000; opb[1] = 32'd3;         opb[2] = 32'd1;  opb[3] = 32'h8000_0000;

    tab[0] = '{mk_op(2'd2, 2'd1, F_ADD,   1, 0, 0), 32'h0000_0008, 4'b0000, 0};
    tab[1] = '{mk_op(2'd1, 2'd2, F_ADD,   1, 0, 0), 32'h0000_0000, 4'b1100, 0};
    tab[2] = '{mk_op(2'd3, 2'd0, F_PASSA, 0, 1, 3), 32'hA1B2_C3D4, 4'b1100, 0};
    tab[3] = '{mk_op(2'd3, 2'd0, F_PASSA, 0, 1, 1), 32'hA1B2_C3D4, 4'b1100, 3};
    tab[4] = '{mk_op(2'd0, 2'd1, F_SUB,   1, 1, 1), 32'hFFFF_FFFD, 4'b0010, 0};
    tab[5] = '{mk_op(2'd3, 2'd3, F_ADD,   1, 1, 0), 32'h21B2_C3D4, 4'b0101, 1};
    tab[6] = '{mk_op(2'd1, 2'd1, F_XOR,   0, 0, 0), 32'hFFFF_FFFC, 4'b0101, 0};
    tab[7] = '{mk_op(2'd2, 2'd0, F_AND,   1, 0, 0), 32'h0000_0000, 4'b1000, 0};
    tab[8] = '{mk_op(2'd0, 2'd3, F_PASSB, 0, 0, 0), 32'h8000_0000, 4'b1000, 0};
    idle_op = mk_op(0, 0, 0, 0, 0, 0);

    rst = 1'b0;
    req_valid = 1'b0;
    byte_ready = 1'b0;
    drive_req(idle_op);
    @(posedge clk);
    #1;
    check_reset_outs();
    tick();
    rst = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_op(tab[i].op, tab[i].exp_data, tab[i].exp_flags, tab[i].stall, 1'b0, idle_op);
    end

    // Busy rejection: valid held high from the first acceptance onward
    c1 = mk_op(2'd3, 2'd0, F_PASSA, 1'b0, 1'b1, 2'd3);
    c2 = mk_op(2'd2, 2'd1, F_ADD,   1'b1, 1'b0, 2'd0);
    acc0 = n_accept;
    e1 = model(c1);
    run_op(c1, e1[31:0], e1[35:32], -1, 1'b1, c2);
    e2 = model(c2);
    run_op(c2, e2[31:0], e2[35:32], 0, 1'b0, idle_op);
    repeat (4) begin
      tick();
      chk("post_busy_res_valid", res_valid, 0);
    end
    chk("busy_accept_count", n_accept - acc0, 2);

    // Reset while byte 1 of 4 is pending
    op_id++;
    drive_req(mk_op(2'd3, 2'd0, F_PASSA, 1'b0, 1'b1, 2'd3));
    req_valid = 1'b1;
    tick();                       // accepted (controller idle)
    req_valid = 1'b0;
    tick(); tick(); tick();       // FLAG, DONE, STORE byte 0
    byte_ready = 1'b1;
    chk("mid_byte0", byte_data, 32'hD4);
    tick();
    byte_ready = 1'b0;
    chk("mid_byte1", byte_data, 32'hC3);
    chk("mid_muxc1", MuxCSel, 1);
    rst = 1'b0;
    #1;
    check_reset_outs();
    byte_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("in_rst_byte_valid", byte_valid, 0);
      chk("in_rst_res_valid", res_valid, 0);
    end
    rst = 1'b1;
    byte_ready = 1'b0;
    tick();
    chk("after_rst_byte_valid", byte_valid, 0);
    chk("after_rst_req_ready", req_ready, 1);

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++) begin
        opa[k] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        opb[k] = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
      end
      rnd = mk_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      er = model(rnd);
      run_op(rnd, er[31:0], er[35:32], -1, 1'b0, idle_op);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_system_controller.md
# alu_system_controller

Sequencer for the ALU system datapath: accepts one operation request at a time over a valid/ready handshake, then drives the ALU operand selects, function select and flag-write strobe for exactly one execute cycle. It captures the 32-bit result and the updated flags. Optionally, it streams the result out byte by byte through the ALU system's byte mux (MuxC) to an 8-bit sink. It sits between the instruction-level control unit and the ALU system.

## Interface
Parameters:
- none; byte count per store is supplied per request (1–4).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_src_a  in  2  operand A select, forwarded to MuxASel
- req_src_b  in  2  operand B select, forwarded to MuxBSel
- req_fun  in  5  ALU function, forwarded to FunSel
- req_wf  in  1  update flags for this op
- req_store  in  1  stream result bytes after execution
- req_nbytes  in  2  bytes to stream minus one (0 → 1 byte, 3 → 4 bytes)
- MuxASel, MuxBSel  out  2 each  to ALU system
- FunSel  out  5  to ALU system
- WF  out  1  flag write strobe to ALU system
- MuxCSel  out  2  byte select to ALU system
- ALUOut  in  32  from ALU system
- Flags  in  4  from ALU system (registered flags)
- MuxCOut  in  8  from ALU system
- res_valid  out  1  one-cycle pulse, result fields valid
- res_data  out  32  captured ALU result
- res_flags  out  4  captured flags
- byte_valid  out  1  byte available
- byte_ready  in  1  sink accepts byte
- byte_data  out  8  equals MuxCOut
- byte_last  out  1  final byte of this result

## Operation
- Command register holds the fields of the accepted request (a, b, fun, wf, store, nbytes). MuxASel, MuxBSel and FunSel are driven from this register in every state.
- IDLE: req_ready=1. On req_valid&&req_ready, load the command register and go to EXEC.
- EXEC, 1 cycle: WF = cmd.wf. Register ALUOut into res_data at the end of the cycle. Go to FLAG.
- FLAG, 1 cycle: WF=0. Register Flags into res_flags; the ALU flag register updated at the EXEC edge. Go to DONE.
- DONE, 1 cycle: res_valid=1. If cmd.store, set the byte index to 0 and go to STORE; otherwise go to IDLE.
- STORE: MuxCSel = index, byte_valid=1, byte_data=MuxCOut, byte_last=(index==cmd.nbytes). Bytes are emitted LSB first.
  - On byte_valid&&byte_ready: if byte_last, go to IDLE; otherwise increment the index.
  - With byte_ready low, state, index and byte_data are held. No timeout.
- WF is high only in EXEC, and never more than one cycle per request.
- req_valid while busy is ignored; the requester holds it until ready.
- Upstream registers feeding MuxA/MuxB must not be written while the controller is busy. res_data is immune to such writes; the streamed bytes are not.

## Timing
- Reset (rst low, asynchronous): state IDLE, command register 0, index 0. Outputs: req_ready=1, MuxASel=MuxBSel=0, FunSel=0, WF=0, MuxCSel=0, res_valid=0, res_data=0, res_flags=0, byte_valid=0, byte_last=0.
- Reset asserted mid-operation aborts immediately: no res_valid, and any partially streamed sequence is dropped.
- Handshake accepted at edge T: EXEC occupies cycle T..T+1, FLAG T+1..T+2, DONE (res_valid) T+2..T+3.
- Without store, req_ready is high again in cycle T+3. Minimum period is 4 cycles per operation.
- With store and the sink always ready, N bytes take N cycles after DONE. req_ready returns the cycle after the last byte is accepted.
- MuxCSel changes only on an accepted byte. byte_data is combinational from MuxCOut and therefore stable while stalled.

## Structure
- Package alu_ctrl_pkg holds the state enum (IDLE, EXEC, FLAG, DONE, STORE), the command struct type and FunSel/select width constants.
- One natural sub-module, alu_byte_serializer: the index counter, the byte handshake and last detection, started by a pulse from the main FSM carrying nbytes.

## Test plan
- Reset mid-STORE: assert rst while byte 1 of 4 is pending → all outputs return immediately to their reset values, req_ready=1, no further bytes.
- Plain op, no store: request fun=add, src_a=2, src_b=1, wf=1 with DR=5 and OutC=3 → WF high exactly 1 cycle, res_valid at accept+2, res_data=8, res_flags equal to the ALU flags after the add, req_ready at accept+3.
- Store 4 bytes, sink always ready: ALUOut=0xA1B2C3D4 → bytes D4, C3, B2, A1 on consecutive cycles, MuxCSel 0..3, byte_last only on A1.
- Store with stalls: nbytes=1, byte_ready held low 3 cycles → byte_data D4 held stable, index frozen, then D4 and C3 are delivered with last on C3.
- Busy rejection: req_valid held high during EXEC through STORE → no second acceptance until IDLE; the second command is taken exactly once.
- wf=0 request: WF stays 0 throughout; res_flags equals the previous flag value.
